// File: rtl/uart_rx_frame_chk.sv
// rtl/uart_rx_frame_chk.sv - UART receive frame tracker: deserializer, parity and stop-bit checker
module uart_rx_frame_chk #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sampled_bit,
  input  logic                  bit_valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CW-1:0]         bit_cnt;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_fail;

  // Frame FSM: advances only on bit strobes; result pulses are registered and last one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_fail   <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (bit_valid) begin
        case (state)
          IDLE: begin
            // A low sample is a start bit; frame config is frozen here
            if (!sampled_bit) begin
              state     <= DATA;
              busy      <= 1'b1;
              par_en_q  <= PAR_EN;
              par_typ_q <= PAR_TYP;
              bit_cnt   <= '0;
              par_fail  <= 1'b0;
            end
          end
          DATA: begin
            shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
              state <= par_en_q ? PARITY : STOP;
            end
          end
          PARITY: begin
            // Even parity bit equals the XOR of the data; odd inverts it
            par_fail <= (sampled_bit != (^shift_reg ^ par_typ_q));
            state    <= STOP;
          end
          STOP: begin
            // A byte is only published when both stop and parity are clean
            if (sampled_bit && !par_fail) begin
              P_DATA     <= shift_reg;
              data_valid <= 1'b1;
            end
            stp_err <= ~sampled_bit;
            par_err <= par_fail;
            state   <= IDLE;
            busy    <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
